// File: rtl/pipeline_fetch_pc_if.sv
// Fetch-PC bundle: stage control/redirect requests in, fetch address and qualifiers out.
// The master side is the PC stage; the slave side is the pipeline control that steers it.
interface pipeline_fetch_pc_if #(
  parameter int XLEN = 32
);
  logic            en_IF;
  logic            PCSrc;
  logic [XLEN-1:0] PC_in_IF;
  logic            trap_IF;
  logic [XLEN-1:0] trap_vec_IF;
  logic [XLEN-1:0] PC_out_IF;
  logic [XLEN-1:0] PC_next_IF;
  logic            fetch_valid_IF;
  logic            redirect_pending_IF;
  logic            misalign_IF;

  modport master (
    input  en_IF, PCSrc, PC_in_IF, trap_IF, trap_vec_IF,
    output PC_out_IF, PC_next_IF, fetch_valid_IF, redirect_pending_IF, misalign_IF
  );

  modport slave (
    output en_IF, PCSrc, PC_in_IF, trap_IF, trap_vec_IF,
    input  PC_out_IF, PC_next_IF, fetch_valid_IF, redirect_pending_IF, misalign_IF
  );
endinterface

// File: rtl/pipeline_fetch_pc.sv
// Fetch-stage PC with trap/branch redirect, stall capture of redirects and post-redirect bubbles.
// State updates on the falling edge of clk_IF; PC_ALIGN_CHECK_EN enables target alignment with a misalign pulse.
module pipeline_fetch_pc #(
  parameter int              XLEN             = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR     = '0,
  parameter int              INST_BYTES       = 4,
  parameter int              REDIRECT_BUBBLES = 1
) (
  input  logic               clk_IF,
  input  logic               rst_IF,
  pipeline_fetch_pc_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

  localparam logic [1:0] BUB_LOAD = 2'(REDIRECT_BUBBLES);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fv_q, fv_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            pend_vld_q, pend_vld_d;
  logic            pend_trap_q, pend_trap_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            redir;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_next;

`ifdef PC_ALIGN_CHECK_EN
  localparam int              OFF        = $clog2(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-OFF){1'b1}}, {OFF{1'b0}}};
  logic mis_q, mis_d;
`endif

  assign pc_next = pc_q + XLEN'(INST_BYTES);

  always_ff @(negedge clk_IF) begin
    if (rst_IF) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      fv_q        <= 1'b0;
      cnt_q       <= 2'd0;
      pend_vld_q  <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_tgt_q  <= '0;
`ifdef PC_ALIGN_CHECK_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fv_q        <= fv_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_trap_q <= pend_trap_d;
      pend_tgt_q  <= pend_tgt_d;
`ifdef PC_ALIGN_CHECK_EN
      mis_q       <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fv_d        = fv_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_trap_d = pend_trap_q;
    pend_tgt_d  = pend_tgt_q;
    redir       = 1'b0;
    tgt         = '0;
`ifdef PC_ALIGN_CHECK_EN
    mis_d       = 1'b0;
`endif
    if (bus.en_IF) begin
      // Live trap beats a held trap, which beats any branch, live or held.
      redir = 1'b1;
      if (bus.trap_IF)                  tgt = bus.trap_vec_IF;
      else if (pend_vld_q && pend_trap_q) tgt = pend_tgt_q;
      else if (bus.PCSrc)               tgt = bus.PC_in_IF;
      else if (pend_vld_q)              tgt = pend_tgt_q;
      else                              redir = 1'b0;

      if (redir) begin
`ifdef PC_ALIGN_CHECK_EN
        pc_d  = tgt & ALIGN_MASK;
        mis_d = |(tgt & ~ALIGN_MASK);
`else
        pc_d  = tgt;
`endif
        pend_vld_d  = 1'b0;
        pend_trap_d = 1'b0;
        if (REDIRECT_BUBBLES > 0) begin
          state_d = BUBBLE;
          cnt_d   = BUB_LOAD;
          fv_d    = 1'b0;
        end else begin
          state_d = RUN;
          fv_d    = 1'b1;
        end
      end else begin
        unique case (state_q)
          BOOT: begin
            state_d = RUN;
            fv_d    = 1'b1;
          end
          RUN: begin
            pc_d = pc_next;
            fv_d = 1'b1;
          end
          BUBBLE: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_d == 2'd0) begin
              state_d = RUN;
              fv_d    = 1'b1;
            end
          end
          default: state_d = BOOT;
        endcase
      end
    end else begin
      // Stalled: remember the redirect so it is not lost; a held trap is never displaced by a branch.
      if (bus.trap_IF) begin
        pend_vld_d  = 1'b1;
        pend_trap_d = 1'b1;
        pend_tgt_d  = bus.trap_vec_IF;
      end else if (bus.PCSrc && !(pend_vld_q && pend_trap_q)) begin
        pend_vld_d  = 1'b1;
        pend_trap_d = 1'b0;
        pend_tgt_d  = bus.PC_in_IF;
      end
    end
  end

  assign bus.PC_out_IF           = pc_q;
  assign bus.PC_next_IF          = pc_next;
  assign bus.fetch_valid_IF      = fv_q;
  assign bus.redirect_pending_IF = pend_vld_q;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.misalign_IF         = mis_q;
`else
  assign bus.misalign_IF         = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_fetch_pc.sv
// Directed bench for pipeline_fetch_pc: RESET_VECTOR=0x100, INST_BYTES=4, REDIRECT_BUBBLES=1.
module tb_pipeline_fetch_pc;

  logic clk_IF = 1'b0;
  logic rst_IF = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  pipeline_fetch_pc_if #(.XLEN(32)) bus ();

  pipeline_fetch_pc #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0100), .INST_BYTES(4), .REDIRECT_BUBBLES(1)
  ) dut (
    .clk_IF(clk_IF),
    .rst_IF(rst_IF),
    .bus   (bus)
  );

  always #5 clk_IF = ~clk_IF;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        fv;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Drive one edge's inputs, queue what the falling edge must produce, then check it on the rising edge.
  task automatic step(input logic rst, input logic en, input logic pcsrc, input logic [31:0] pcin,
                      input logic trap, input logic [31:0] tvec,
                      input logic [31:0] epc, input logic efv, input logic epend, input logic emis,
                      input string tag);
    exp_t e;
    rst_IF          = rst;
    bus.en_IF       = en;
    bus.PCSrc       = pcsrc;
    bus.PC_in_IF    = pcin;
    bus.trap_IF     = trap;
    bus.trap_vec_IF = tvec;
    sb.push_back('{tag, epc, efv, epend, emis});
    @(negedge clk_IF);
    @(posedge clk_IF);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},   bus.PC_out_IF,                   e.pc);
      chk({e.tag, ".next"}, bus.PC_next_IF,                  e.pc + 32'd4);
      chk({e.tag, ".fv"},   {31'd0, bus.fetch_valid_IF},      {31'd0, e.fv});
      chk({e.tag, ".pend"}, {31'd0, bus.redirect_pending_IF}, {31'd0, e.pend});
      chk({e.tag, ".mis"},  {31'd0, bus.misalign_IF},         {31'd0, e.mis});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] mis_pc;
    logic        mis_flag;
`ifdef PC_ALIGN_CHECK_EN
    mis_pc   = 32'h400;
    mis_flag = 1'b1;
`else
    mis_pc   = 32'h402;
    mis_flag = 1'b0;
`endif
    //      rst en  br  br_tgt         tr  tr_vec        pc             fv  pnd mis  tag
    step(1, 0, 0, 32'h0,          0, 32'h0,      32'h100,        0, 0, 0, "reset");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h100,        1, 0, 0, "boot");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h104,        1, 0, 0, "seq1");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h108,        1, 0, 0, "seq2");
    step(0, 1, 1, 32'h200,        0, 32'h0,      32'h200,        0, 0, 0, "br200");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h200,        1, 0, 0, "bub200");
    step(0, 1, 1, 32'h400,        0, 32'h0,      32'h400,        0, 0, 0, "br400");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h400,        1, 0, 0, "bub400");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h404,        1, 0, 0, "seq404");
    step(0, 1, 1, 32'h400,        1, 32'h80,     32'h80,         0, 0, 0, "trap_vs_br");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h80,         1, 0, 0, "bub80");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h84,         1, 0, 0, "seq84");
    step(0, 0, 1, 32'h300,        0, 32'h0,      32'h84,         1, 1, 0, "stall_br");
    step(0, 0, 0, 32'h0,          1, 32'h80,     32'h84,         1, 1, 0, "stall_trap");
    step(0, 0, 0, 32'h0,          0, 32'h0,      32'h84,         1, 1, 0, "stall_hold");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h80,         0, 0, 0, "pend_trap_apply");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h80,         1, 0, 0, "bub_after_pend");
    step(0, 0, 1, 32'h500,        0, 32'h0,      32'h80,         1, 1, 0, "stall_br500");
    step(0, 0, 1, 32'h600,        0, 32'h0,      32'h80,         1, 1, 0, "stall_br600");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h600,        0, 0, 0, "newer_br_wins");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h600,        1, 0, 0, "bub600");
    step(0, 0, 0, 32'h0,          1, 32'h700,    32'h600,        1, 1, 0, "stall_tr700");
    step(0, 0, 1, 32'h800,        0, 32'h0,      32'h600,        1, 1, 0, "stall_br_ignored");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h700,        0, 0, 0, "held_trap_kept");
    step(0, 0, 1, 32'h900,        1, 32'h740,    32'h700,        0, 1, 0, "stall_both");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h740,        0, 0, 0, "both_trap_taken");
    step(0, 0, 0, 32'h0,          1, 32'h780,    32'h740,        0, 1, 0, "stall_tr780");
    step(0, 1, 1, 32'hA00,        0, 32'h0,      32'h780,        0, 0, 0, "pend_trap_vs_live_br");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h780,        1, 0, 0, "bub780");
    step(0, 1, 1, 32'h1000,       0, 32'h0,      32'h1000,       0, 0, 0, "br1000");
    step(0, 1, 1, 32'h2000,       0, 32'h0,      32'h2000,       0, 0, 0, "redir_in_bubble");
    step(0, 0, 0, 32'h0,          0, 32'h0,      32'h2000,       0, 0, 0, "stall_in_bubble");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h2000,       1, 0, 0, "bub2000");
    step(0, 1, 1, 32'hFFFF_FFFC,  0, 32'h0,      32'hFFFF_FFFC,  0, 0, 0, "br_top");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'hFFFF_FFFC,  1, 0, 0, "bub_top");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h0,          1, 0, 0, "wrap");
    step(0, 1, 1, 32'h40,         0, 32'h0,      32'h40,         0, 0, 0, "br40");
    step(0, 0, 1, 32'h50,         0, 32'h0,      32'h40,         0, 1, 0, "stall_br50");
    step(1, 1, 1, 32'h60,         1, 32'h70,     32'h100,        0, 0, 0, "reset_mid_bubble");
    step(0, 1, 0, 32'h0,          0, 32'h0,      32'h100,        1, 0, 0, "reboot");
    step(0, 1, 1, 32'h402,        0, 32'h0,      mis_pc,         0, 0, mis_flag, "br402");
    step(0, 1, 0, 32'h0,          0, 32'h0,      mis_pc,         1, 0, 0, "mis_pulse_end");
    step(0, 1, 0, 32'h0,          0, 32'h0,      mis_pc + 32'd4, 1, 0, 0, "seq_after_mis");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
